// File: rtl/ro_pair_response.sv
// ro_pair_response: compares two ring oscillators chosen by an 8-bit challenge.
//
// The challenge selects RO A (challenge_i[7:4]) and RO B (challenge_i[3:0]). Rising edges of
// both are counted over a fixed window of clk cycles. The counts are then compared and a
// response bit is produced together with the raw counts and status flags.
//
// Ports:
//   clk_i               system clock
//   rst_i               synchronous, active-high reset
//   challenge_i         [7:4] RO index A, [3:0] RO index B
//   challenge_valid_i   challenge present
//   challenge_ready_o   idle and able to accept a challenge
//   ro_i                raw ring-oscillator outputs (asynchronous to clk_i)
//   ro_en_o             oscillator enables
//   response_o          1 when count_a_o > count_b_o
//   response_valid_o    one-cycle strobe: response and status are valid
//   count_a_o/count_b_o edges counted on RO A / RO B
//   tie_o               count_a_o == count_b_o
//   sat_o               either counter saturated
//   sel_err_o           invalid selection (A == B or an index >= NUM_RO)
//
// Optional feature: define RO_GATE_EN to drive ro_en_o from a register that enables only the
// two selected oscillators during ARM and COUNT. Without it ro_en_o is constant all-ones.

module ro_pair_response #(
    parameter int unsigned NUM_RO = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WINDOW = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        challenge_i,
    input  logic              challenge_valid_i,
    output logic              challenge_ready_o,
    input  logic [NUM_RO-1:0] ro_i,
    output logic [NUM_RO-1:0] ro_en_o,
    output logic              response_o,
    output logic              response_valid_o,
    output logic [CNT_W-1:0]  count_a_o,
    output logic [CNT_W-1:0]  count_b_o,
    output logic              tie_o,
    output logic              sat_o,
    output logic              sel_err_o
);

    localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StCount,
        StCompare,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Synchronisers and rising-edge detection
    // ------------------------------------------------------------------
    logic [NUM_RO-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_RO-1:0] rise;
    logic [15:0]       rise_pad;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

    // Widened to 16 so a 4-bit index is always in range, whatever NUM_RO is.
    always_comb begin
        rise_pad = '0;
        rise_pad[NUM_RO-1:0] = rise;
    end

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              arm_q, arm_d;
    logic [WinW-1:0]   win_q, win_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic              sat_int_q, sat_int_d;
    logic [3:0]        idx_a_q, idx_a_d;
    logic [3:0]        idx_b_q, idx_b_d;
    logic              ready_q, ready_d;
    logic              response_q, response_d;
    logic              tie_q, tie_d;
    logic              sat_q, sat_d;
    logic              sel_err_q, sel_err_d;
    logic [CNT_W-1:0]  count_a_q, count_a_d;
    logic [CNT_W-1:0]  count_b_q, count_b_d;
    logic              accept;
    logic              sel_bad;

    assign accept  = challenge_valid_i && ready_q;
    assign sel_bad = (challenge_i[7:4] == challenge_i[3:0])
                  || (32'(challenge_i[7:4]) >= NUM_RO)
                  || (32'(challenge_i[3:0]) >= NUM_RO);

    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        win_d      = win_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        sat_int_d  = sat_int_q;
        idx_a_d    = idx_a_q;
        idx_b_d    = idx_b_q;
        response_d = response_q;
        tie_d      = tie_q;
        sat_d      = sat_q;
        sel_err_d  = sel_err_q;
        count_a_d  = count_a_q;
        count_b_d  = count_b_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_a_d = challenge_i[7:4];
                    idx_b_d = challenge_i[3:0];
                    if (sel_bad) begin
                        // Report the error immediately with cleared results.
                        state_d    = StDone;
                        sel_err_d  = 1'b1;
                        response_d = 1'b0;
                        tie_d      = 1'b0;
                        sat_d      = 1'b0;
                        count_a_d  = '0;
                        count_b_d  = '0;
                    end else begin
                        state_d   = StArm;
                        sel_err_d = 1'b0;
                        arm_d     = 1'b0;
                    end
                end
            end
            StArm: begin
                // Two cycles: lets synchroniser contents from before the
                // selection (or before the enable) drain out.
                cnt_a_d   = '0;
                cnt_b_d   = '0;
                sat_int_d = 1'b0;
                win_d     = WinW'(WINDOW - 1);
                arm_d     = 1'b1;
                if (arm_q) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                if (rise_pad[idx_a_q] && (cnt_a_q != CntMax)) begin
                    cnt_a_d = cnt_a_q + CNT_W'(1);
                end
                if (rise_pad[idx_b_q] && (cnt_b_q != CntMax)) begin
                    cnt_b_d = cnt_b_q + CNT_W'(1);
                end
                if ((cnt_a_d == CntMax) || (cnt_b_d == CntMax)) begin
                    sat_int_d = 1'b1;
                end
                if (win_q == '0) begin
                    state_d = StCompare;
                end else begin
                    win_d = win_q - WinW'(1);
                end
            end
            StCompare: begin
                response_d = (cnt_a_q > cnt_b_q);
                tie_d      = (cnt_a_q == cnt_b_q);
                sat_d      = sat_int_q;
                count_a_d  = cnt_a_q;
                count_b_d  = cnt_b_q;
                state_d    = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so that ready stays low for the whole reset and rises the cycle after.
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            arm_q      <= 1'b0;
            win_q      <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            sat_int_q  <= 1'b0;
            idx_a_q    <= '0;
            idx_b_q    <= '0;
            ready_q    <= 1'b0;
            response_q <= 1'b0;
            tie_q      <= 1'b0;
            sat_q      <= 1'b0;
            sel_err_q  <= 1'b0;
            count_a_q  <= '0;
            count_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            win_q      <= win_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            sat_int_q  <= sat_int_d;
            idx_a_q    <= idx_a_d;
            idx_b_q    <= idx_b_d;
            ready_q    <= ready_d;
            response_q <= response_d;
            tie_q      <= tie_d;
            sat_q      <= sat_d;
            sel_err_q  <= sel_err_d;
            count_a_q  <= count_a_d;
            count_b_q  <= count_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Oscillator enables
    // ------------------------------------------------------------------
`ifdef RO_GATE_EN
    logic [NUM_RO-1:0] ro_en_q, ro_en_d;
    logic [15:0]       en_pad;

    // Driven from next-state so the enables line up exactly with ARM/COUNT.
    always_comb begin
        en_pad = '0;
        if ((state_d == StArm) || (state_d == StCount)) begin
            en_pad[idx_a_d] = 1'b1;
            en_pad[idx_b_d] = 1'b1;
        end
        ro_en_d = en_pad[NUM_RO-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ro_en_q <= '0;
        end else begin
            ro_en_q <= ro_en_d;
        end
    end

    assign ro_en_o = ro_en_q;
`else
    assign ro_en_o = '1;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign challenge_ready_o = ready_q;
    assign response_valid_o  = (state_q == StDone);
    assign response_o        = response_q;
    assign tie_o             = tie_q;
    assign sat_o             = sat_q;
    assign sel_err_o         = sel_err_q;
    assign count_a_o         = count_a_q;
    assign count_b_o         = count_b_q;

endmodule

// File: tb/tb_ro_pair_response.sv
// Directed bench for ro_pair_response. Main instance uses WINDOW=64, CNT_W=16; a second
// instance with CNT_W=4 exercises counter saturation. Latency is counted with the accepting
// edge as edge 1, so a valid challenge reports on edge 68 and an invalid one on edge 1.

module tb_ro_pair_response;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ro  = '0;

    logic [7:0]  challenge = '0;
    logic        cvalid = 1'b0;
    logic        ready, rv, resp, tie, sat, sel_err;
    logic [15:0] count_a, count_b, ro_en;

    logic [7:0]  challenge2 = '0;
    logic        cvalid2 = 1'b0;
    logic        ready2, rv2, resp2, tie2, sat2, sel_err2;
    logic [3:0]  count_a2, count_b2;
    logic [15:0] ro_en2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ro_pair_response #(.NUM_RO(16), .CNT_W(16), .WINDOW(64)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .challenge_i       (challenge),
        .challenge_valid_i (cvalid),
        .challenge_ready_o (ready),
        .ro_i              (ro),
        .ro_en_o           (ro_en),
        .response_o        (resp),
        .response_valid_o  (rv),
        .count_a_o         (count_a),
        .count_b_o         (count_b),
        .tie_o             (tie),
        .sat_o             (sat),
        .sel_err_o         (sel_err)
    );

    ro_pair_response #(.NUM_RO(16), .CNT_W(4), .WINDOW(64)) dut_sat (
        .clk_i             (clk),
        .rst_i             (rst),
        .challenge_i       (challenge2),
        .challenge_valid_i (cvalid2),
        .challenge_ready_o (ready2),
        .ro_i              (ro),
        .ro_en_o           (ro_en2),
        .response_o        (resp2),
        .response_valid_o  (rv2),
        .count_a_o         (count_a2),
        .count_b_o         (count_b2),
        .tie_o             (tie2),
        .sat_o             (sat2),
        .sel_err_o         (sel_err2)
    );

    always #5 clk = ~clk;

    // Oscillator models, changing 2 time units after each clk edge.
    // ro[0]: period 2, ro[1]/ro[2]: period 8 (identical), ro[3]: period 4, ro[5]: period 6.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            ro[0] = cyc[0];
            ro[1] = cyc[2];
            ro[2] = cyc[2];
            ro[3] = cyc[1];
            ro[5] = ((cyc / 3) % 2) == 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs, input int lo,
                               input int hi);
        checks++;
        assert ((int'(obs) >= lo) && (int'(obs) <= hi)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Issue a challenge and return the edge number (accept edge = 1) of response_valid.
    // Returns 0 if no response appears within the budget. Leaves time at the negedge of the
    // response cycle.
    task automatic run(input logic [7:0] ch, input bit hold, input logic [15:0] exp_en,
                       output int lat);
        @(negedge clk);
        challenge = ch;
        cvalid    = 1'b1;
        lat       = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) cvalid = 1'b0;
            if (hold && n == 30) check("busy_ready", 32'(ready), 32'd0);
            if (n == 10) begin
`ifdef RO_GATE_EN
                check("ro_en_count", 32'(ro_en), 32'(exp_en));
`else
                check("ro_en_free", 32'(ro_en), 32'hffff);
`endif
            end
            if (rv) begin
                lat = n;
                break;
            end
        end
        cvalid = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",   32'(ready),   32'd0);
        check("rst_rv",      32'(rv),      32'd0);
        check("rst_count_a", 32'(count_a), 32'd0);
        check("rst_count_b", 32'(count_b), 32'd0);
        check("rst_flags",   32'({resp, tie, sat, sel_err}), 32'd0);
`ifdef RO_GATE_EN
        check("rst_ro_en", 32'(ro_en), 32'd0);
`else
        check("rst_ro_en", 32'(ro_en), 32'hffff);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready), 32'd1);

        // Basic compare: A=ro[3] (16 edges), B=ro[5] (~10.7 edges)
        run(8'h35, 1'b0, 16'h0028, lat);
        check("lat_35", 32'(lat), 32'd68);
        check_range("count_a_35", 32'(count_a), 15, 17);
        check_range("count_b_35", 32'(count_b), 9, 11);
        check("resp_35",    32'(resp),    32'd1);
        check("tie_35",     32'(tie),     32'd0);
        check("sat_35",     32'(sat),     32'd0);
        check("sel_err_35", 32'(sel_err), 32'd0);
        check("ready_done", 32'(ready),   32'd0);
`ifdef RO_GATE_EN
        check("ro_en_done", 32'(ro_en), 32'd0);
`endif

        // Swapped selection
        run(8'h53, 1'b0, 16'h0028, lat);
        check("lat_53", 32'(lat), 32'd68);
        check_range("count_a_53", 32'(count_a), 9, 11);
        check_range("count_b_53", 32'(count_b), 15, 17);
        check("resp_53", 32'(resp), 32'd0);
        check("tie_53",  32'(tie),  32'd0);

        // Identical oscillators: counts equal, tie
        run(8'h12, 1'b0, 16'h0006, lat);
        check("lat_12", 32'(lat), 32'd68);
        check_range("count_a_12", 32'(count_a), 7, 9);
        check("count_eq_12", 32'(count_b), 32'(count_a));
        check("tie_12",  32'(tie),  32'd1);
        check("resp_12", 32'(resp), 32'd0);

        // Busy: challenge_valid held high through the whole operation
        run(8'h35, 1'b1, 16'h0028, lat);
        check("lat_busy",  32'(lat),  32'd68);
        check("resp_busy", 32'(resp), 32'd1);
        @(negedge clk);
        check("rv_after_busy", 32'(rv), 32'd0);

        // Reset mid-COUNT aborts without a response
        challenge = 8'h35;
        cvalid    = 1'b1;
        @(negedge clk);
        cvalid = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready",   32'(ready),   32'd0);
        check("midrst_rv",      32'(rv),      32'd0);
        check("midrst_count_a", 32'(count_a), 32'd0);
        check("midrst_count_b", 32'(count_b), 32'd0);
        check("midrst_flags",   32'({resp, tie, sat, sel_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 32'(ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rv) seen = 1'b1;
        end
        check("midrst_no_rv", 32'(seen), 32'd0);

        // Invalid selection (A == B)
        run(8'h77, 1'b0, 16'h0000, lat);
        check("lat_77",     32'(lat),     32'd1);
        check("sel_err_77", 32'(sel_err), 32'd1);
        check("count_a_77", 32'(count_a), 32'd0);
        check("count_b_77", 32'(count_b), 32'd0);
        check("flags_77",   32'({resp, tie, sat}), 32'd0);
        check("ready_77",   32'(ready),   32'd0);
        @(negedge clk);
        check("ready_after_77", 32'(ready), 32'd1);
        check("rv_after_77",    32'(rv),    32'd0);
        check("sel_err_hold",   32'(sel_err), 32'd1);

        // Saturation on the CNT_W=4 instance: A=ro[0] (~32 edges), B=ro[1] (8 edges)
        challenge2 = 8'h01;
        cvalid2    = 1'b1;
        lat        = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            cvalid2 = 1'b0;
            if (rv2) begin
                lat = n;
                break;
            end
        end
        check("lat_sat",     32'(lat),      32'd68);
        check("count_a_sat", 32'(count_a2), 32'd15);
        check_range("count_b_sat", 32'(count_b2), 7, 9);
        check("sat_sat",     32'(sat2),     32'd1);
        check("resp_sat",    32'(resp2),    32'd1);
        check("tie_sat",     32'(tie2),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
